// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// multi-cycle main memory. Loads that hit return data in the same cycle. Load
// misses, and every store, hold the core with stall until main memory has
// finished. Each line holds one 32-bit word.
module dm_cache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    state_t state_q;

    // Registered memory-side outputs
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // Line storage: only the valid bits are reset
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    // Saturating statistics
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_d;

    // CPU address decode
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  unused_addr_bits;

    assign idx              = cpu_addr[INDEX_BITS+1:2];
    assign tag              = cpu_addr[ADDR_W-1:INDEX_BITS+2];
    // Byte offset within the word plays no part in a word-wide cache
    assign unused_addr_bits = ^cpu_addr[1:0];

    // The pending fill targets the line whose address was registered when the miss was issued
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;

    assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_BITS+2];

    // Request decode. Everything is qualified by reset, so nothing is
    // decoded while reset is held low.
    logic idle;
    logic line_hit;
    logic do_write;
    logic do_read;
    logic read_hit;
    logic read_miss;
    logic write_hit;
    logic fill_en;
    logic busy;

    assign idle      = reset && (state_q == IDLE);
    assign line_hit  = valid_q[idx] && (tag_mem[idx] == tag);
    // A store takes priority; a read asserted in the same cycle is dropped
    assign do_write  = idle && cpu_write;
    assign do_read   = idle && cpu_read && !cpu_write;
    assign read_hit  = do_read && line_hit;
    assign read_miss = do_read && !line_hit;
    assign write_hit = do_write && line_hit;
    assign fill_en   = reset && (state_q == RD_WAIT) && mem_ready;
    assign busy      = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    // Core-facing outputs are combinational so that a hit completes in the same cycle
    assign stall     = reset && (read_miss || do_write || busy);
    assign cpu_rdata = read_hit ? data_mem[idx] : 32'd0;

    // Per-line set mask for the valid bits on a refill
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            localparam logic [INDEX_BITS-1:0] LINE_IDX = INDEX_BITS'(gi);
            assign valid_d[gi] = valid_q[gi] || (fill_en && (fill_idx == LINE_IDX));
        end
    endgenerate

    // Counters stop at all-ones instead of wrapping
    assign hit_cnt_d  = (read_hit  && (hit_cnt_q  != {CNT_W{1'b1}})) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
    assign miss_cnt_d = (read_miss && (miss_cnt_q != {CNT_W{1'b1}})) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;

    // Valid bits and statistics, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag/data arrays: a refill from memory, or a store that hits (write-through keeps the line coherent)
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_idx] <= mem_rdata;
            tag_mem[fill_idx]  <= fill_tag;
        end else if (write_hit) begin
            data_mem[idx] <= cpu_wdata;
        end
    end

    // Controller FSM with registered memory request outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (do_write) begin
                        mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= cpu_wdata;
                        mem_we_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        state_q     <= WR_WAIT;
                    end else if (read_miss) begin
                        mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_we_q    <= 1'b0;
                        mem_req_q   <= 1'b1;
                        state_q     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // The line is refilled on this edge; the retry in IDLE then hits
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    // One unstalled cycle lets the store retire; any request seen here
                    // belongs to the old PC and is ignored
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl
// Table-driven vectors applied through a scoreboard queue, a behavioural main
// memory with fixed latency, and hand-written reset and saturation sequences.
module tb_dm_cache_ctrl;

    localparam int INDEX_BITS = 5;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;
    localparam int LAT        = 3;

    logic              clk;
    logic              reset;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    dm_cache_ctrl #(
        .INDEX_BITS (INDEX_BITS),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main memory model ----------------
    // Word at byte address A lives in mem_model[A[9:2]]; default contents 0x5A00_0000 + word.
    logic [31:0] mem_model [0:255];
    int          req_age;
    logic        prev_req;
    int          req_issued = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] <= 32'h5A00_0000 + 32'(i);
        mem_model[16] <= 32'h1234_5678;
    end

    // mem_ready is raised during the LAT-th cycle that mem_req is high
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready <= 1'b0;
            req_age   <= 0;
            prev_req  <= 1'b0;
        end else begin
            prev_req  <= mem_req;
            mem_ready <= 1'b0;
            if (mem_req && !prev_req) begin
                req_issued <= req_issued + 1;
                cap_we     <= mem_we;
                cap_addr   <= mem_addr;
                cap_wdata  <= mem_wdata;
            end
            if (mem_req && !mem_ready) begin
                if (req_age + 1 >= LAT - 1) begin
                    mem_ready <= 1'b1;
                    req_age   <= 0;
                    if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
                    else        mem_rdata <= mem_model[mem_addr[9:2]];
                end else begin
                    req_age <= req_age + 1;
                end
            end
        end
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        int          exp_reqs;
        logic        exp_we;
        logic [31:0] exp_maddr;
        logic [15:0] exp_hit;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    vec_t sb_q[$];

    int n_vec   = 0;
    int n_fail  = 0;
    int n_check = 0;

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int stalls, int reqs, logic we,
                                logic [31:0] maddr, logic [15:0] hit, logic [15:0] miss);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_stalls = stalls; v.exp_reqs = reqs;
        v.exp_we = we; v.exp_maddr = maddr; v.exp_hit = hit; v.exp_miss = miss;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, id, act, exp);
        end
    endtask

    // Drive one request and hold it until the cycle where stall is low
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rdat, output logic to);
        stalls = 0; rdat = '0; to = 1'b0;
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        forever begin
            @(negedge clk);
            if (!stall) begin
                rdat = cpu_rdata;
                break;
            end
            stalls++;
            if (stalls > 50) begin
                to = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic apply_vec(input int id, input vec_t v);
        vec_t        e;
        int          stalls;
        int          reqs0;
        logic [31:0] rdat;
        logic        to;
        sb_q.push_back(v);
        reqs0 = req_issued;
        run_txn(v.rd, v.wr, v.addr, v.wdata, stalls, rdat, to);
        e = sb_q.pop_front();
        n_vec++;
        check("timeout",   id, {31'd0, to}, 32'd0);
        check("stalls",    id, stalls, e.exp_stalls);
        check("cpu_rdata", id, rdat, e.exp_rdata);
        check("mem_reqs",  id, req_issued - reqs0, e.exp_reqs);
        if (e.exp_reqs == 1) begin
            check("mem_we",   id, {31'd0, cap_we}, {31'd0, e.exp_we});
            check("mem_addr", id, cap_addr, e.exp_maddr);
            if (e.exp_we) check("mem_wdata", id, cap_wdata, e.wdata);
        end
        check("hit_count",  id, hit_count,  e.exp_hit);
        check("miss_count", id, miss_count, e.exp_miss);
        $display("vec %0d rd=%0b wr=%0b addr=%h rdata=%h stalls=%0d hits=%0d misses=%0d",
                 id, v.rd, v.wr, v.addr, rdat, stalls, hit_count, miss_count);
    endtask

    initial begin
        // rd wr addr wdata | rdata stalls reqs we maddr hit miss
        vecs_a.push_back(mk(1, 0, 32'h40,  0,            32'h1234_5678, 4, 1, 0, 32'h40,  1, 1));
        vecs_a.push_back(mk(1, 0, 32'h40,  0,            32'h1234_5678, 0, 0, 0, 0,       2, 1));
        vecs_a.push_back(mk(0, 1, 32'h40,  32'hDEAD_BEEF, 32'h0,        4, 1, 1, 32'h40,  2, 1));
        vecs_a.push_back(mk(1, 0, 32'h40,  0,            32'hDEAD_BEEF, 0, 0, 0, 0,       3, 1));
        vecs_a.push_back(mk(0, 1, 32'h80,  32'hCAFE_F00D, 32'h0,        4, 1, 1, 32'h80,  3, 1));
        vecs_a.push_back(mk(1, 0, 32'h80,  0,            32'hCAFE_F00D, 4, 1, 0, 32'h80,  4, 2));
        vecs_a.push_back(mk(1, 0, 32'hC0,  0,            32'h5A00_0030, 4, 1, 0, 32'hC0,  5, 3));
        vecs_a.push_back(mk(1, 0, 32'h40,  0,            32'hDEAD_BEEF, 4, 1, 0, 32'h40,  6, 4));
        vecs_a.push_back(mk(1, 0, 32'hC0,  0,            32'h5A00_0030, 4, 1, 0, 32'hC0,  7, 5));
        vecs_a.push_back(mk(1, 1, 32'h100, 32'h0BAD_F00D, 32'h0,        4, 1, 1, 32'h100, 7, 5));
        vecs_a.push_back(mk(0, 0, 32'h40,  0,            32'h0,        0, 0, 0, 0,       7, 5));
        vecs_a.push_back(mk(1, 0, 32'h107, 0,            32'h5A00_0041, 4, 1, 0, 32'h104, 8, 6));
        vecs_a.push_back(mk(1, 0, 32'h104, 0,            32'h5A00_0041, 0, 0, 0, 0,       9, 6));
        vecs_a.push_back(mk(1, 0, 32'h100, 0,            32'h0BAD_F00D, 4, 1, 0, 32'h100, 10, 7));
        // after a reset taken in the middle of a refill of 0x200
        vecs_b.push_back(mk(1, 0, 32'h104, 0,            32'h5A00_0041, 4, 1, 0, 32'h104, 1, 1));
        vecs_b.push_back(mk(1, 0, 32'h200, 0,            32'h5A00_0080, 4, 1, 0, 32'h200, 2, 2));
        vecs_b.push_back(mk(1, 0, 32'h100, 0,            32'h0BAD_F00D, 4, 1, 0, 32'h100, 3, 3));
        vecs_b.push_back(mk(1, 0, 32'h104, 0,            32'h5A00_0041, 0, 0, 0, 0,       4, 3));

        // Reset state, with a read request already present
        reset = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        check("rst_stall",     0, {31'd0, stall},   0);
        check("rst_mem_req",   0, {31'd0, mem_req}, 0);
        check("rst_mem_we",    0, {31'd0, mem_we},  0);
        check("rst_mem_addr",  0, mem_addr,  0);
        check("rst_mem_wdata", 0, mem_wdata, 0);
        check("rst_cpu_rdata", 0, cpu_rdata, 0);
        check("rst_hit",       0, hit_count,  0);
        check("rst_miss",      0, miss_count, 0);
        $display("reset: stall=%0b mem_req=%0b hits=%0d misses=%0d", stall, mem_req, hit_count, miss_count);
        cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs_a.size(); i++) apply_vec(i + 1, vecs_a[i]);

        // Reset asserted while a refill is outstanding
        n_vec++;
        cpu_read = 1'b1; cpu_addr = 32'h200;
        @(negedge clk);
        check("mid_miss_stall", 100, {31'd0, stall}, 1);
        @(negedge clk);
        check("mid_rdwait_req", 100, {31'd0, mem_req}, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req",   100, {31'd0, mem_req}, 0);
        check("mid_rst_stall", 100, {31'd0, stall},   0);
        cpu_read = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_hit",   100, hit_count,  0);
        check("mid_rst_miss",  100, miss_count, 0);
        check("mid_rst_req2",  100, {31'd0, mem_req}, 0);
        $display("mid-refill reset: mem_req=%0b stall=%0b hits=%0d misses=%0d", mem_req, stall, hit_count, miss_count);
        @(posedge clk); #1;

        for (int i = 0; i < vecs_b.size(); i++) apply_vec(200 + i, vecs_b[i]);

        // Back-to-back hits on one line up to and past saturation
        n_vec++;
        cpu_read = 1'b1; cpu_addr = 32'h104;
        repeat (65530) @(posedge clk);
        #1;
        check("sat_hit_pre", 300, hit_count, 32'hFFFE);
        check("sat_stall",   300, {31'd0, stall}, 0);
        repeat (4) @(posedge clk);
        #1;
        check("sat_hit",     300, hit_count,  32'hFFFF);
        check("sat_miss",    300, miss_count, 3);
        check("sat_rdata",   300, cpu_rdata,  32'h5A00_0041);
        $display("saturation: hits=%0d misses=%0d", hit_count, miss_count);
        cpu_read = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
